axi_rd_slave: RTL
=================

# axi_rd_slave

AXI4 read-channel responder (slave) that terminates the arbitrated read path downstream of the master-side read multiplexer. It accepts one AR transaction at a time, generates FIXED/INCR/WRAP beat addresses and returns R beats from an internal word memory with correct RID, RRESP and RLAST. A backdoor write port preloads the memory for system use and test.

## Interface
- MEM_DEPTH, 1024: memory depth in 32-bit words; power of two, at least 2.
- AW, $clog2(MEM_DEPTH): word-index width; derived, not overridden.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axi_arid  in  4  read ID.
- s_axi_araddr  in  32  byte start address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_arsize  in  3  log2 bytes per beat.
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- s_axi_arvalid  in  1  AR valid.
- s_axi_arready  out  1  AR ready.
- s_axi_rid  out  4  captured ARID.
- s_axi_rdata  out  32  beat data.
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR.
- s_axi_rlast  out  1  final beat.
- s_axi_rvalid  out  1  R valid.
- s_axi_rready  in  1  R ready.
- mem_we  in  1  backdoor write enable.
- mem_waddr  in  AW  backdoor word index.
- mem_wdata  in  32  backdoor write data.

## Operation
- FSM states IDLE and DATA; reset state IDLE.
- IDLE: arready=1. On arvalid&arready, capture id, addr, len, size, burst; clear beat counter; load rdata/rresp for beat 0; enter DATA.
- DATA: arready=0, rvalid=1. rlast=1 when beat counter equals captured len. On rvalid&rready: if rlast, enter IDLE; else increment counter, advance address, load next beat's rdata/rresp.
- Increment = 1<<size. FIXED: address unchanged. INCR and reserved 11: address+increment, 32-bit wrap-around (no 4 KB check). WRAP: mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+incr) & mask).
- Beat data: whole word mem[addr[AW+1:2]]; no lane shifting for narrow sizes.
- rresp SLVERR for a beat when addr[31:2] >= MEM_DEPTH (rdata forced 0), for the whole burst when size > 2 or burst = 11, or when burst = WRAP with len not in {1,3,7,15}; otherwise OKAY. Error bursts still return exactly len+1 beats.
- Backdoor: on mem_we, mem[mem_waddr] <= mem_wdata at the clock edge, in any state. Same-edge read load of same word returns old data (read-before-write). Memory is not reset.

## Timing
- Reset values: arready 0, rvalid 0, rlast 0, rid 0, rdata 0, rresp 00, state IDLE.
- arready rises on the first edge after aresetn deasserts.
- AR handshake at edge N -> rvalid and beat 0 visible after edge N; latency 1 cycle.
- rid, rdata, rresp, rlast stable while rvalid=1 and rready=0.
- Beat k handshake at edge M -> beat k+1 visible after edge M; full throughput with rready held high.
- Last-beat handshake at edge M -> rvalid=0 and arready=1 after edge M; next AR may handshake at edge M+1 (one bubble between bursts).
- arvalid never combinationally affects any output; arready depends only on state.
- aresetn assertion mid-burst aborts immediately: all outputs to reset values asynchronously; no remaining beats issued.

## Test plan
- mem[4..7]=A0..A3; AR id 3, addr 0x10, len 3, size 2, INCR, rready=1 -> 4 beats A0,A1,A2,A3, rid 3, OKAY, rlast on beat 3 only, arready back 1 cycle after last.
- WRAP len 3 size 2 addr 0x38 -> word addresses 0x38,0x3C,0x30,0x34; len 2 WRAP -> 3 beats all SLVERR.
- FIXED len 7 addr 0x20, mem[8]=5A5A5A5A -> 8 beats of 5A5A5A5A; rlast on eighth.
- INCR len 1 from word MEM_DEPTH-1 -> beat 0 OKAY with data, beat 1 SLVERR with rdata 0; size 3 burst -> all SLVERR.
- Random rready toggling over INCR len 15 -> R outputs held stable while stalled; 16 beats in order, no drop or duplicate.
- aresetn pulsed low during beat 2 of len 7 -> rvalid 0 immediately; after release arready 1 next edge and fresh burst returns correct data.

Source files
------------

// File: rtl/axi_rd_slave.sv
// AXI4 read-channel slave: one AR at a time, FIXED/INCR/WRAP beat addressing,
// R beats from an internal word memory that is preloaded through a backdoor port.
module axi_rd_slave #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [3:0]    s_axi_arid,
  input  logic [31:0]   s_axi_araddr,
  input  logic [7:0]    s_axi_arlen,
  input  logic [2:0]    s_axi_arsize,
  input  logic [1:0]    s_axi_arburst,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  output logic [3:0]    s_axi_rid,
  output logic [31:0]   s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          s_axi_rlast,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [31:0]   mem_wdata
);

  typedef enum logic {IDLE, DATA} state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] MEM_BYTES  = 32'(MEM_DEPTH) << 2;

  state_e      state_q, state_d;
  logic        init_q;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        berr_q, berr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [31:0] mem [MEM_DEPTH];

  logic [31:0] incr, wrap_mask, next_addr;
  logic        load_en, load_berr;
  logic [31:0] load_addr;

  // Errors that apply to every beat of a burst, decided once at AR time.
  function automatic logic ar_burst_err(input logic [7:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
    logic bad_wrap_len;
    bad_wrap_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size > 3'd2) || (burst == BURST_RSVD) || (burst == BURST_WRAP && bad_wrap_len);
  endfunction

  always_comb begin
    incr      = 32'd1 << size_q;
    wrap_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default:     next_addr = addr_q + incr;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
    berr_d    = berr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    load_en   = 1'b0;
    load_addr = addr_q;
    load_berr = berr_q;

    case (state_q)
      IDLE: begin
        if (s_axi_arvalid && init_q) begin
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          len_d     = s_axi_arlen;
          size_d    = s_axi_arsize;
          burst_d   = s_axi_arburst;
          cnt_d     = 8'd0;
          berr_d    = ar_burst_err(s_axi_arlen, s_axi_arsize, s_axi_arburst);
          load_en   = 1'b1;
          load_addr = s_axi_araddr;
          load_berr = berr_d;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (s_axi_rready) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            cnt_d     = cnt_q + 8'd1;
            addr_d    = next_addr;
            load_en   = 1'b1;
            load_addr = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat data is registered here, so a same-edge backdoor write is not seen.
    if (load_en) begin
      if (load_berr || (load_addr >= MEM_BYTES)) begin
        rdata_d = 32'd0;
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = mem[load_addr[AW+1:2]];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      berr_q  <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  // init_q holds arready low for the first edge after reset release.
  assign s_axi_arready = (state_q == IDLE) && init_q;
  assign s_axi_rvalid  = (state_q == DATA);
  assign s_axi_rlast   = (state_q == DATA) && (cnt_q == len_q);
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule
